// File: rtl/simmem_release_scheduler.sv
// Per-ID release timing for the simulated memory response bank: gates which IDs the
// bank may release, enforcing an arrival latency, a per-ID gap and round-robin fairness.
module simmem_release_scheduler #(
  parameter int unsigned IDWidth      = 4,
  parameter int unsigned DelayWidth   = 8,
  parameter int unsigned ArrivalDelay = 10,
  parameter int unsigned GapDelay     = 2,
  parameter int unsigned MaxPending   = 7
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       enq_valid_i,
  input  logic [IDWidth-1:0]         enq_id_i,
  output logic                       enq_ready_o,
  input  logic [(1<<IDWidth)-1:0]    released_onehot_i,
  output logic [(1<<IDWidth)-1:0]    release_en_o,
  output logic                       idle_o
);

  localparam int unsigned NumIds   = 1 << IDWidth;
  localparam int unsigned CntWidth = $clog2(MaxPending + 1);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StWait = 2'd1;
  localparam logic [1:0] StElig = 2'd2;

  localparam logic [CntWidth-1:0]   MaxCnt      = CntWidth'(MaxPending);
  localparam logic [CntWidth-1:0]   CntOne      = CntWidth'(1);
  localparam logic [DelayWidth-1:0] TimerOne    = DelayWidth'(1);
  // The cycle that loads the timer counts as the first delay cycle, hence the -1.
  localparam logic [DelayWidth-1:0] ArrivalLoad = DelayWidth'(ArrivalDelay - 1);
  localparam logic [DelayWidth-1:0] GapLoad     = DelayWidth'(GapDelay);

  logic [1:0]            state_q [NumIds];
  logic [1:0]            state_d [NumIds];
  logic [CntWidth-1:0]   pend_q  [NumIds];
  logic [CntWidth-1:0]   pend_d  [NumIds];
  logic [DelayWidth-1:0] timer_q [NumIds];
  logic [DelayWidth-1:0] timer_d [NumIds];
  logic [IDWidth-1:0]    rr_q;
  logic [IDWidth-1:0]    rr_d;

  logic                  enq_hs;
  logic [NumIds-1:0]     enq_sel;
  logic [NumIds-1:0]     elig_vec;
  logic [NumIds-1:0]     rel_acc;
  logic [NumIds-1:0]     upper_mask;
  logic [NumIds-1:0]     elig_upper;

  assign enq_ready_o = (pend_q[enq_id_i] != MaxCnt);
  assign enq_hs      = enq_valid_i && enq_ready_o;
  assign rel_acc     = released_onehot_i & elig_vec;
  assign elig_upper  = elig_vec & upper_mask;

  always_comb begin
    enq_sel    = '0;
    elig_vec   = '0;
    upper_mask = '0;
    idle_o     = 1'b1;
    for (int k = 0; k < NumIds; k++) begin
      enq_sel[k]    = enq_hs && (enq_id_i == IDWidth'(k));
      elig_vec[k]   = (state_q[k] == StElig);
      upper_mask[k] = (IDWidth'(k) >= rr_q);
      if (state_q[k] != StIdle) begin
        idle_o = 1'b0;
      end
    end
  end

  // Prefer eligible IDs at or above the pointer; fall back to all of them on wrap.
  assign release_en_o = (elig_upper != '0) ? elig_upper : elig_vec;

  always_comb begin
    rr_d = rr_q;
    for (int k = 0; k < NumIds; k++) begin
      if (rel_acc[k]) begin
        rr_d = IDWidth'(k + 1);
      end
    end
  end

  always_comb begin
    for (int k = 0; k < NumIds; k++) begin
      state_d[k] = state_q[k];
      pend_d[k]  = pend_q[k];
      timer_d[k] = timer_q[k];
      if (rel_acc[k]) begin
        // A same-cycle accepted enqueue replaces the released message: no change at all.
        if (!enq_sel[k]) begin
          if (pend_q[k] == CntOne) begin
            state_d[k] = StIdle;
            pend_d[k]  = '0;
            timer_d[k] = '0;
          end else begin
            pend_d[k] = pend_q[k] - CntOne;
            if (GapDelay != 0) begin
              state_d[k] = StWait;
              timer_d[k] = GapLoad;
            end
          end
        end
      end else begin
        case (state_q[k])
          StIdle: begin
            if (enq_sel[k]) begin
              pend_d[k] = CntOne;
              if (ArrivalDelay <= 1) begin
                state_d[k] = StElig;
              end else begin
                state_d[k] = StWait;
                timer_d[k] = ArrivalLoad;
              end
            end
          end
          StWait: begin
            if (enq_sel[k]) begin
              pend_d[k] = pend_q[k] + CntOne;
            end
            if (timer_q[k] <= TimerOne) begin
              state_d[k] = StElig;
              timer_d[k] = '0;
            end else begin
              timer_d[k] = timer_q[k] - TimerOne;
            end
          end
          StElig: begin
            if (enq_sel[k]) begin
              pend_d[k] = pend_q[k] + CntOne;
            end
          end
          default: begin
            state_d[k] = StIdle;
            pend_d[k]  = '0;
            timer_d[k] = '0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_q <= '0;
      for (int k = 0; k < NumIds; k++) begin
        state_q[k] <= StIdle;
        pend_q[k]  <= '0;
        timer_q[k] <= '0;
      end
    end else begin
      rr_q <= rr_d;
      for (int k = 0; k < NumIds; k++) begin
        state_q[k] <= state_d[k];
        pend_q[k]  <= pend_d[k];
        timer_q[k] <= timer_d[k];
      end
    end
  end

  // The bank may only release IDs it was allowed to, and at most one per cycle.
  a_rel_onehot0 : assert property (@(posedge clk_i) disable iff (!rst_ni)
    $onehot0(released_onehot_i));
  a_rel_only_elig : assert property (@(posedge clk_i) disable iff (!rst_ni)
    ((released_onehot_i & ~elig_vec) == '0));

endmodule

// File: tb/tb_simmem_release_scheduler.sv
// Scoreboard bench for simmem_release_scheduler: a cycle-stamped reference model predicts
// every cycle's outputs, and a negedge monitor compares them against the DUT.
module tb_simmem_release_scheduler;

  localparam int IdW  = 4;
  localparam int DlyW = 8;
  localparam int ArrD = 10;
  localparam int GapD = 2;
  localparam int MaxP = 7;
  localparam int N    = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          enq_valid;
  logic [IdW-1:0] enq_id;
  logic          enq_ready;
  logic [N-1:0]  rel;
  logic [N-1:0]  rel_en;
  logic          idle;

  always #5 clk = ~clk;

  simmem_release_scheduler #(
    .IDWidth(IdW), .DelayWidth(DlyW), .ArrivalDelay(ArrD),
    .GapDelay(GapD), .MaxPending(MaxP)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .enq_valid_i(enq_valid), .enq_id_i(enq_id),
    .enq_ready_o(enq_ready), .released_onehot_i(rel), .release_en_o(rel_en),
    .idle_o(idle)
  );

  typedef struct {
    logic [N-1:0] en;
    logic         rdy;
    logic         idl;
    longint       cyc;
  } exp_t;

  exp_t   expQ[$];
  int     nChecks = 0;
  int     nFails  = 0;

  // Reference model: pending count per ID plus the absolute cycle it becomes eligible.
  int     pend   [N];
  longint eligAt [N];
  int     rr;
  longint cyc = 0;

  function automatic logic [N-1:0] modelElig();
    logic [N-1:0] e = '0;
    for (int k = 0; k < N; k++) e[k] = (pend[k] > 0) && (cyc >= eligAt[k]);
    return e;
  endfunction

  function automatic logic [N-1:0] modelEnables();
    logic [N-1:0] e = modelElig();
    logic [N-1:0] m = '0;
    for (int k = 0; k < N; k++) if (k >= rr) m[k] = e[k];
    return (m != '0) ? m : e;
  endfunction

  function automatic logic modelIdle();
    for (int k = 0; k < N; k++) if (pend[k] != 0) return 1'b0;
    return 1'b1;
  endfunction

  function automatic void modelReset();
    for (int k = 0; k < N; k++) begin
      pend[k]   = 0;
      eligAt[k] = 0;
    end
    rr = 0;
  endfunction

  function automatic void modelStep(bit v, int id, logic [N-1:0] r);
    logic [N-1:0] e = modelElig();
    bit hs = v && (pend[id] != MaxP);
    int relId = -1;
    for (int k = 0; k < N; k++) if (r[k] && e[k]) relId = k;
    if (!(hs && relId == id)) begin
      if (hs) begin
        if (pend[id] == 0) eligAt[id] = cyc + ArrD;
        pend[id]++;
      end
      if (relId >= 0) begin
        pend[relId]--;
        if (pend[relId] > 0) eligAt[relId] = cyc + 1 + GapD;
      end
    end
    if (relId >= 0) rr = (relId + 1) % N;
    cyc++;
  endfunction

  function automatic logic [N-1:0] pickRelease();
    logic [N-1:0] e = modelEnables();
    int idx[$];
    for (int k = 0; k < N; k++) if (e[k]) idx.push_back(k);
    if (idx.size() == 0) return '0;
    return N'(1) << idx[$urandom_range(0, idx.size() - 1)];
  endfunction

  task automatic applyStimulus(bit v, int id, logic [N-1:0] r);
    exp_t e;
    @(posedge clk);
    #1;
    rst_n     = 1'b1;
    enq_valid = v;
    enq_id    = IdW'(id);
    rel       = r;
    e.en  = modelEnables();
    e.rdy = (pend[id] != MaxP);
    e.idl = modelIdle();
    e.cyc = cyc;
    expQ.push_back(e);
    modelStep(v, id, r);
  endtask

  task automatic applyReset(int n);
    exp_t e;
    repeat (n) begin
      @(posedge clk);
      #1;
      rst_n     = 1'b0;
      enq_valid = 1'b0;
      rel       = '0;
      modelReset();
      e.en  = '0;
      e.rdy = 1'b1;
      e.idl = 1'b1;
      e.cyc = cyc;
      expQ.push_back(e);
      cyc++;
    end
  endtask

  task automatic checkOutput(exp_t e);
    nChecks++;
    if (rel_en !== e.en) begin
      nFails++;
      $display("[TB] FAIL release_en cycle %0d: got %h expected %h", e.cyc, rel_en, e.en);
    end
    nChecks++;
    if (enq_ready !== e.rdy) begin
      nFails++;
      $display("[TB] FAIL enq_ready cycle %0d: got %b expected %b", e.cyc, enq_ready, e.rdy);
    end
    nChecks++;
    if (idle !== e.idl) begin
      nFails++;
      $display("[TB] FAIL idle cycle %0d: got %b expected %b", e.cyc, idle, e.idl);
    end
  endtask

  always @(negedge clk) begin
    if (expQ.size() > 0) checkOutput(expQ.pop_front());
  end

  task automatic idleCycles(int n);
    repeat (n) applyStimulus(1'b0, 0, '0);
  endtask

  task automatic waitEnabled(int id);
    logic [N-1:0] e;
    int guard = 0;
    e = modelEnables();
    while (!e[id] && guard < 200) begin
      applyStimulus(1'b0, 0, '0);
      guard++;
      e = modelEnables();
    end
    if (!e[id]) begin
      nChecks++;
      nFails++;
      $display("[TB] FAIL waitEnabled id %0d: got disabled expected enabled", id);
    end
  endtask

  task automatic drainId(int id);
    int guard = 0;
    while (pend[id] > 0 && guard < 300) begin
      waitEnabled(id);
      applyStimulus(1'b0, 0, N'(1) << id);
      guard++;
    end
  endtask

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n     = 1'b0;
    enq_valid = 1'b0;
    enq_id    = '0;
    rel       = '0;
    modelReset();
    applyReset(3);

    // Single message on ID 3: enable 10 cycles after enqueue, released two cycles later.
    idleCycles(5);
    applyStimulus(1'b1, 3, '0);
    waitEnabled(3);
    idleCycles(2);
    applyStimulus(1'b0, 0, N'(1) << 3);
    idleCycles(2);

    // Three back-to-back messages on ID 2, each released on its first enabled cycle.
    repeat (3) applyStimulus(1'b1, 2, '0);
    repeat (3) begin
      waitEnabled(2);
      applyStimulus(1'b0, 0, N'(1) << 2);
    end
    idleCycles(2);

    // Fill ID 5 to the limit, refused enqueue, release with refused enqueue, then net-zero.
    repeat (MaxP) applyStimulus(1'b1, 5, '0);
    applyStimulus(1'b1, 5, '0);
    applyStimulus(1'b0, 6, '0);
    waitEnabled(5);
    applyStimulus(1'b1, 5, N'(1) << 5);
    applyStimulus(1'b0, 5, '0);
    waitEnabled(5);
    applyStimulus(1'b1, 5, N'(1) << 5);
    applyStimulus(1'b0, 5, '0);
    drainId(5);

    // Round robin from pointer 0 with IDs 1 (two pending) and 4.
    applyStimulus(1'b1, 15, '0);
    drainId(15);
    applyStimulus(1'b1, 1, '0);
    applyStimulus(1'b1, 1, '0);
    applyStimulus(1'b1, 4, '0);
    waitEnabled(4);
    applyStimulus(1'b0, 0, N'(1) << 1);
    idleCycles(4);
    drainId(4);
    drainId(1);

    // Pointer wrap: pointer 15 with IDs 0 and 15 eligible.
    applyStimulus(1'b1, 14, '0);
    drainId(14);
    applyStimulus(1'b1, 0, '0);
    applyStimulus(1'b1, 15, '0);
    waitEnabled(15);
    applyStimulus(1'b0, 0, N'(1) << 15);
    idleCycles(1);
    drainId(0);

    // Reset with several IDs outstanding, then a fresh enqueue.
    applyStimulus(1'b1, 1, '0);
    applyStimulus(1'b1, 3, '0);
    applyStimulus(1'b1, 7, '0);
    applyStimulus(1'b1, 9, '0);
    idleCycles(ArrD);
    applyReset(2);
    idleCycles(3);
    applyStimulus(1'b1, 4, '0);
    idleCycles(ArrD + 2);
    drainId(4);

    // Randomized traffic biased towards a few IDs so the pending limit is reached.
    for (int i = 0; i < 3000; i++) begin
      bit v;
      int id;
      logic [N-1:0] r;
      v  = ($urandom_range(0, 1) == 1);
      id = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 3)) : int'($urandom_range(0, N - 1));
      r  = ($urandom_range(0, 3) != 0) ? pickRelease() : '0;
      if ($urandom_range(0, 599) == 0) applyReset(2);
      else applyStimulus(v, id, r);
    end
    idleCycles(2);

    repeat (2) @(posedge clk);
    nChecks++;
    if (expQ.size() != 0) begin
      nFails++;
      $display("[TB] FAIL scoreboard drain: got %0d entries expected 0", expQ.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
